// File: rtl/mask_pack_pkg.sv
// Shared types and sizing helpers for the mask/pack scheduler.
// Optional statistics ports are enabled by defining PACK_STATS_EN.
package mask_pack_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int STAT_LANES_W = 32;
  localparam int STAT_PKTS_W  = 16;

  // Width that holds a lane count from 0 up to 2*lanes-1.
  function automatic int lane_cnt_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/lane_prefix_cnt.sv
// Prefix stage: registers the incoming beat together with the inclusive
// prefix popcount of its mask, pc[i] = mask[0] + ... + mask[i].
module lane_prefix_cnt
  import mask_pack_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int LANE_W = 8,
  localparam int CW    = lane_cnt_w(LANES)
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic [LANES*LANE_W-1:0] s_data,
  input  logic [LANES-1:0]        s_mask,
  input  logic                    s_last,
  output logic [LANES*LANE_W-1:0] p_data,
  output logic [LANES-1:0]        p_mask,
  output logic                    p_last,
  output logic [LANES*CW-1:0]     pc
);

  logic [LANES*CW-1:0] pc_c;

  // Running sum of mask bits, one tap per lane.
  always_comb begin : prefix_sum
    logic [CW-1:0] run;
    run  = '0;
    pc_c = '0;
    for (int i = 0; i < LANES; i++) begin
      run = run + CW'(s_mask[i]);
      pc_c[i*CW +: CW] = run;
    end
  end

  // Capture the beat on an input transfer; data needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      p_data <= s_data;
      p_mask <= s_mask;
      p_last <= s_last;
      pc     <= pc_c;
    end
  end

endmodule

// File: rtl/mask_pack_sched.sv
// Mask-driven lane packer: compacts the masked lanes of a sparse stream into
// dense output beats, preserving packet boundaries.
// Define PACK_STATS_EN to add the stat_lanes / stat_pkts counters.
//
// Handshake: on both streams a beat transfers in exactly the cycle where
// valid and ready are both 1; a valid beat holds all its payload stable until
// it transfers, and ready may depend combinationally on internal state only.
module mask_pack_sched
  import mask_pack_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int LANE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*LANE_W-1:0]   s_data,
  input  logic [LANES-1:0]          s_mask,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*LANE_W-1:0]   m_data,
  output logic [LANES-1:0]          m_keep,
  output logic                      m_last,
`ifdef PACK_STATS_EN
  output logic [STAT_LANES_W-1:0]   stat_lanes,
  output logic [STAT_PKTS_W-1:0]    stat_pkts,
`endif
  output logic                      dbg_state,
  output logic [$clog2(LANES):0]    dbg_fill
);

  localparam int CW    = lane_cnt_w(LANES);
  localparam int SLOTS = 2 * LANES;
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  state_t                    state, state_n;
  logic                      p_valid;
  logic [LANES*LANE_W-1:0]   p_data;
  logic [LANES-1:0]          p_mask;
  logic                      p_last;
  logic [LANES*CW-1:0]       pc;
  logic [CW-1:0]             pc_last;
  logic [CW-1:0]             fill, fill_s, fill_n;
  logic [CW-1:0]             slot;
  logic [LANE_W-1:0]         acc   [SLOTS];
  logic [LANE_W-1:0]         acc_n [SLOTS];
  logic                      s_xfer, out_xfer, absorb, full;

  assign s_xfer  = s_valid && s_ready;
  assign pc_last = pc[(LANES-1)*CW +: CW];

  lane_prefix_cnt #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_prefix (
    .clk    (clk),
    .load   (s_xfer),
    .s_data (s_data),
    .s_mask (s_mask),
    .s_last (s_last),
    .p_data (p_data),
    .p_mask (p_mask),
    .p_last (p_last),
    .pc     (pc)
  );

  // Prefix-stage occupancy: set on input transfer, cleared once absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
    end else if (s_xfer) begin
      p_valid <= 1'b1;
    end else if (absorb) begin
      p_valid <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state: last beat absorbed enters FLUSH, last beat sent leaves it.
  always_comb begin
    state_n = state;
    case (state)
      ACCUM:   if (absorb && p_last)   state_n = FLUSH;
      FLUSH:   if (out_xfer && m_last) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  // FSM outputs and handshake decode; everything here is a function of
  // registered state, so m_* cannot move while the beat is stalled.
  always_comb begin
    full     = (fill >= LANES_C);
    absorb   = p_valid && (state == ACCUM) && !full;
    s_ready  = !p_valid || absorb;
    m_valid  = full || (state == FLUSH);
    m_last   = (state == FLUSH) && (fill <= LANES_C);
    out_xfer = m_valid && m_ready;
    m_keep   = '0;
    for (int i = 0; i < LANES; i++) begin
      m_keep[i] = full || (CW'(i) < fill);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_mdata
    assign m_data[g*LANE_W +: LANE_W] = acc[g];
  end

  // Accumulator update: shift out the sent beat first, then scatter the
  // absorbed lanes starting at the post-shift fill.
  always_comb begin
    fill_s = fill;
    slot   = '0;
    for (int j = 0; j < SLOTS; j++) begin
      acc_n[j] = acc[j];
    end
    if (out_xfer) begin
      for (int j = 0; j < LANES; j++) begin
        acc_n[j] = acc[j+LANES];
      end
      fill_s = full ? (fill - LANES_C) : '0;
    end
    fill_n = fill_s;
    if (absorb) begin
      for (int i = 0; i < LANES; i++) begin
        if (p_mask[i]) begin
          slot        = fill_s + pc[i*CW +: CW] - CW'(1);
          acc_n[slot] = p_data[i*LANE_W +: LANE_W];
        end
      end
      fill_n = fill_s + pc_last;
    end
  end

  // Fill count register; reset discards any buffered lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else begin
      fill <= fill_n;
    end
  end

  // Accumulator lane storage, no reset needed.
  always_ff @(posedge clk) begin
    for (int j = 0; j < SLOTS; j++) begin
      acc[j] <= acc_n[j];
    end
  end

  assign dbg_state = state;
  assign dbg_fill  = fill;

`ifdef PACK_STATS_EN
  logic [STAT_LANES_W:0] lanes_sum;

  assign lanes_sum = {1'b0, stat_lanes} + (STAT_LANES_W+1)'(pc_last);

  // Saturating lane counter and wrapping packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lanes <= '0;
      stat_pkts  <= '0;
    end else begin
      if (absorb) begin
        stat_lanes <= lanes_sum[STAT_LANES_W] ? '1 : lanes_sum[STAT_LANES_W-1:0];
      end
      if (out_xfer && m_last) begin
        stat_pkts <= stat_pkts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mask_pack_sched.sv
// Self-checking bench for mask_pack_sched (default LANES=16, LANE_W=8).
module tb_mask_pack_sched;

  localparam int L  = 16;
  localparam int W  = 8;
  localparam int DW = L * W;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [L-1:0]  s_mask;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [L-1:0]  m_keep;
  logic          m_last;
  logic          dbg_state;
  logic [4:0]    dbg_fill;
`ifdef PACK_STATS_EN
  logic [31:0]   stat_lanes;
  logic [15:0]   stat_pkts;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] in_data_q[$];
  logic [L-1:0]  in_mask_q[$];
  logic          in_last_q[$];
  logic [DW-1:0] exp_q[$];
  logic [L-1:0]  exp_keep_q[$];
  logic          exp_last_q[$];
  logic [W-1:0]  pend_q[$];
  bit            drv_done;

  mask_pack_sched #(.LANES(L), .LANE_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_mask    (s_mask),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
`ifdef PACK_STATS_EN
    .stat_lanes(stat_lanes),
    .stat_pkts (stat_pkts),
`endif
    .dbg_state (dbg_state),
    .dbg_fill  (dbg_fill)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] keep_bits(input logic [L-1:0] k);
    logic [DW-1:0] b;
    b = '0;
    for (int i = 0; i < L; i++) if (k[i]) b[i*W +: W] = '1;
    return b;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [L-1:0] rand_mask();
    int sel;
    sel = $urandom_range(3, 0);
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    return L'($urandom);
  endfunction

  function automatic void add_beat(input logic [DW-1:0] d, input logic [L-1:0] m, input logic lst);
    in_data_q.push_back(d);
    in_mask_q.push_back(m);
    in_last_q.push_back(lst);
  endfunction

  // Reference model: pop n compacted lanes as one output beat.
  function automatic void emit(input int n, input logic lst);
    logic [DW-1:0] d;
    logic [L-1:0]  k;
    d = '0;
    k = '0;
    for (int kk = 0; kk < n; kk++) begin
      d[kk*W +: W] = pend_q.pop_front();
      k[kk] = 1'b1;
    end
    exp_q.push_back(d);
    exp_keep_q.push_back(k);
    exp_last_q.push_back(lst);
  endfunction

  // Reference model: lanes of a packet are concatenated in order; a full
  // beat leaves as soon as L lanes are waiting; at packet end the remainder
  // (possibly none) leaves with last set.
  function automatic void build_expected();
    pend_q.delete();
    for (int b = 0; b < in_data_q.size(); b++) begin
      for (int i = 0; i < L; i++)
        if (in_mask_q[b][i]) pend_q.push_back(in_data_q[b][i*W +: W]);
      if (in_last_q[b]) begin
        while (pend_q.size() > L) emit(L, 1'b0);
        emit(pend_q.size(), 1'b1);
      end else if (pend_q.size() >= L) begin
        emit(L, 1'b0);
      end
    end
  endfunction

  // Driver: sends queued beats with optional idle gaps.
  task automatic drive_all(input int gapmax);
    int gap;
    int w;
    while (in_data_q.size() > 0) begin
      gap = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data  = in_data_q.pop_front();
      s_mask  = in_mask_q.pop_front();
      s_last  = in_last_q.pop_front();
      w = 0;
      @(negedge clk);
      while (!s_ready && w < 500) begin @(negedge clk); w++; end
      if (!s_ready) begin
        checks++; errors++;
        $display("FAIL drive_timeout: s_ready=%b required 1", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
    end
    drv_done = 1'b1;
  endtask

  // Monitor / scoreboard: m_ready pattern 0=always, 1=toggle 1010, 2=random.
  task automatic monitor(input int rmode);
    int cyc;
    int idle;
    logic stalled;
    logic [DW-1:0] h_data;
    logic [L-1:0]  h_keep;
    logic          h_last;
    logic [DW-1:0] e;
    logic [L-1:0]  ek;
    logic          el;
    cyc = 0; idle = 0; stalled = 1'b0;
    h_data = '0; h_keep = '0; h_last = 1'b0;
    m_ready = (rmode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
    while (idle < 6 && cyc < 3000) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (m_valid !== 1'b1 || m_keep !== h_keep || m_last !== h_last ||
            (m_data & keep_bits(h_keep)) !== h_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b keep=%h last=%b data=%h required valid=1 keep=%h last=%b data=%h",
                   m_valid, m_keep, m_last, m_data & keep_bits(h_keep), h_keep, h_last, h_data);
        end
      end
      checks++;
      if (s_ready !== 1'b1 && !(dbg_fill >= 5'd16 || dbg_state === 1'b1)) begin
        errors++;
        $display("FAIL ready_stall: s_ready=%b fill=%0d state=%b required ready while fill<16 in ACCUM",
                 s_ready, dbg_fill, dbg_state);
      end
      if (m_valid === 1'b1 && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: keep=%h last=%b data=%h required no beat", m_keep, m_last, m_data);
        end else begin
          e = exp_q.pop_front(); ek = exp_keep_q.pop_front(); el = exp_last_q.pop_front();
          if (m_keep !== ek || m_last !== el || (m_data & keep_bits(ek)) !== e) begin
            errors++;
            $display("FAIL out_beat: keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                     m_keep, m_last, m_data & keep_bits(ek), ek, el, e);
          end
        end
      end
      stalled = (m_valid === 1'b1) && !m_ready;
      h_keep = m_keep; h_last = m_last; h_data = m_data & keep_bits(m_keep);
      if (drv_done && exp_q.size() == 0) idle++;
      @(posedge clk); #1;
      cyc++;
      if (drv_done && exp_q.size() == 0) m_ready = 1'b1;
      else if (rmode == 1) m_ready = (cyc % 2 == 0);
      else if (rmode == 2) m_ready = 1'($urandom_range(1, 0));
      else m_ready = 1'b1;
    end
    if (cyc >= 3000) begin
      checks++; errors++;
      $display("FAIL monitor_timeout: %0d beats outstanding required 0", exp_q.size());
    end
    m_ready = 1'b1;
  endtask

  task automatic run_packets(input int rmode, input int gapmax);
    build_expected();
    drv_done = 1'b0;
    fork
      drive_all(gapmax);
      monitor(rmode);
    join
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_mask = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: %b required 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_mlast: %b required 0", m_last); end
    checks++; if (dbg_fill !== 5'd0) begin errors++; $display("FAIL reset_fill: %0d required 0", dbg_fill); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: %b required 0", dbg_state); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready: %b required 1", s_ready); end
    @(posedge clk); #1;
  endtask

  // Single full beat: m_valid two clock edges after the transfer edge.
  task automatic test_full_beat();
    logic [DW-1:0] d;
    apply_reset();
    d = rand_data();
    s_valid = 1'b1; s_data = d; s_mask = 16'hFFFF; s_last = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL lat_sready: %b required 1", s_ready); end
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_early: m_valid=%b required 0", m_valid); end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_keep !== 16'hFFFF || m_last !== 1'b1 || m_data !== d) begin
      errors++;
      $display("FAIL lat_beat: valid=%b keep=%h last=%b data=%h required valid=1 keep=ffff last=1 data=%h",
               m_valid, m_keep, m_last, m_data, d);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL lat_after: valid=%b state=%b required valid=0 state=0", m_valid, dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sparse_pack();
    add_beat(rand_data(), 16'h00FF, 1'b0);
    add_beat(rand_data(), 16'h0F0F, 1'b0);
    add_beat(rand_data(), 16'h8001, 1'b1);
    run_packets(0, 0);
  endtask

  task automatic test_empty_packet();
    add_beat(rand_data(), 16'h0000, 1'b1);
    run_packets(0, 0);
  endtask

  task automatic test_stream_toggle();
    for (int b = 0; b < 10; b++) add_beat(rand_data(), 16'hFFFF, b == 9);
    run_packets(1, 0);
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    s_valid = 1'b1; s_data = rand_data(); s_mask = 16'h01FF; s_last = 1'b0;
    @(posedge clk); #1 s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dbg_fill !== 5'd9 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill: fill=%0d valid=%b required fill=9 valid=0", dbg_fill, m_valid);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || dbg_fill !== 5'd0 || s_ready !== 1'b1 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b fill=%0d ready=%b state=%b required 0 0 1 0",
               m_valid, dbg_fill, s_ready, dbg_state);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    add_beat(rand_data(), 16'hFFFF, 1'b1);
    run_packets(0, 0);
  endtask

  task automatic test_random();
    int nb;
    for (int p = 0; p < 8; p++) begin
      nb = $urandom_range(4, 1);
      for (int b = 0; b < nb; b++) add_beat(rand_data(), rand_mask(), b == nb - 1);
    end
    run_packets(2, 2);
  endtask

  task automatic test_back_to_back();
    int nb;
    for (int p = 0; p < 6; p++) begin
      nb = $urandom_range(3, 1);
      for (int b = 0; b < nb; b++) add_beat(rand_data(), rand_mask(), b == nb - 1);
    end
    run_packets(0, 0);
  endtask

`ifdef PACK_STATS_EN
  task automatic test_stats();
    int exp_lanes;
    int exp_pkts;
    apply_reset();
    add_beat(rand_data(), 16'hFFFF, 1'b1);
    add_beat(rand_data(), 16'hFFFF, 1'b1);
    add_beat(rand_data(), 16'h00FF, 1'b1);
    exp_lanes = 0; exp_pkts = 0;
    for (int b = 0; b < in_mask_q.size(); b++) begin
      exp_lanes += $countones(in_mask_q[b]);
      if (in_last_q[b]) exp_pkts++;
    end
    run_packets(0, 0);
    @(negedge clk);
    checks++;
    if (stat_lanes !== 32'(exp_lanes)) begin
      errors++; $display("FAIL stat_lanes: %0d required %0d", stat_lanes, exp_lanes);
    end
    checks++;
    if (stat_pkts !== 16'(exp_pkts)) begin
      errors++; $display("FAIL stat_pkts: %0d required %0d", stat_pkts, exp_pkts);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    s_valid = 1'b0; s_data = '0; s_mask = '0; s_last = 1'b0; m_ready = 1'b1; rst_n = 1'b0;
    drv_done = 1'b0;
    test_reset();
    test_full_beat();
    test_sparse_pack();
    test_empty_packet();
    test_stream_toggle();
    test_reset_mid_packet();
    test_random();
    test_back_to_back();
`ifdef PACK_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
